// File: rtl/spi_msg_arbiter.sv
// Round-robin drain of four SPI channel FIFOs into one framed word stream
// (channel tag, SOP/EOP), running on the FIFO read-side system clock.
module spi_msg_arbiter #(
    parameter int N_CH    = 4,
    parameter int HOLDOFF = 3
) (
    input  logic                SYS_CLK,
    input  logic                RST,
    input  logic [N_CH-1:0]     CH_EN,
    input  logic [N_CH-1:0]     GOT_FULL_MSG,
    input  logic [8*N_CH-1:0]   MSG_LEN,
    input  logic [16*N_CH-1:0]  FIFO_Q,
    output logic [N_CH-1:0]     RD_REQ,
    input  logic                OUT_READY,
    output logic [15:0]         OUT_DATA,
    output logic                OUT_VALID,
    output logic                OUT_SOP,
    output logic                OUT_EOP,
    output logic [1:0]          OUT_CH,
    output logic                BUSY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [3:0] HOLDOFF_CNT = 4'(HOLDOFF);

    state_t      state_q, state_d;
    logic [7:0]  word_cnt_q, word_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        first_q, first_d;
    logic [1:0]  cur_ch_q, cur_ch_d;
    logic [1:0]  last_ch_q, last_ch_d;
    logic [1:0]  out_ch_q, out_ch_d;
    logic        out_valid_q, out_sop_q, out_eop_q;

    logic [7:0]      len_arr  [N_CH];
    logic [15:0]     data_arr [N_CH];
    logic [N_CH-1:0] req;
    logic            grant_valid;
    logic [1:0]      grant_ch;
    logic [1:0]      cand;
    logic            rd_issue;

    assign rd_issue = OUT_READY && (state_q == S_READ) && !RST;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign len_arr[gi]  = MSG_LEN[8*gi +: 8];
            assign data_arr[gi] = FIFO_Q[16*gi +: 16];
            assign RD_REQ[gi]   = rd_issue && (cur_ch_q == 2'(gi));
        end
    endgenerate

    // Scan from the largest offset down so the nearest channel after last_ch wins.
    always_comb begin
        req         = GOT_FULL_MSG & CH_EN;
        grant_valid = 1'b0;
        grant_ch    = last_ch_q;
        cand        = last_ch_q;
        for (int i = N_CH; i >= 1; i--) begin
            cand = last_ch_q + 2'(i);
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        first_d    = first_q;
        cur_ch_d   = cur_ch_q;
        last_ch_d  = last_ch_q;
        out_ch_d   = out_ch_q;
        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    cur_ch_d   = grant_ch;
                    last_ch_d  = grant_ch;
                    out_ch_d   = grant_ch;
                    word_cnt_d = len_arr[grant_ch];
                    first_d    = 1'b1;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                // A length of 0 wraps through 255 and so drains 256 words.
                if (rd_issue) begin
                    word_cnt_d = word_cnt_q - 8'd1;
                    first_d    = 1'b0;
                    if (word_cnt_q == 8'd1) begin
                        state_d   = S_GAP;
                        gap_cnt_d = HOLDOFF_CNT;
                    end
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - 4'd1;
                if (gap_cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            first_q     <= 1'b0;
            cur_ch_q    <= 2'd0;
            last_ch_q   <= 2'd3;
            out_ch_q    <= 2'd0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            first_q     <= first_d;
            cur_ch_q    <= cur_ch_d;
            last_ch_q   <= last_ch_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= rd_issue;
            out_sop_q   <= rd_issue && first_q;
            out_eop_q   <= rd_issue && (word_cnt_q == 8'd1);
        end
    end

    assign OUT_DATA  = data_arr[cur_ch_q];
    assign OUT_VALID = out_valid_q;
    assign OUT_SOP   = out_sop_q;
    assign OUT_EOP   = out_eop_q;
    assign OUT_CH    = out_ch_q;
    assign BUSY      = (state_q == S_READ) || (state_q == S_GAP);

endmodule

// File: tb/tb_spi_msg_arbiter.sv
// Bench for spi_msg_arbiter: emulated channel FIFOs feed the arbiter and the
// framed output is compared with a message-level round-robin reference model.
module tb_spi_msg_arbiter;

    localparam int HOLDOFF = 3;

    typedef struct packed {
        logic        last;
        logic [15:0] d;
    } fw_t;

    typedef struct packed {
        logic [1:0]  ch;
        logic        sop;
        logic        eop;
        logic [15:0] d;
    } ow_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ch_en = 4'hF;
    logic [3:0]  got;
    logic [31:0] msg_len;
    logic [63:0] fifo_q;
    logic [3:0]  rd_req;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_valid, out_sop, out_eop, busy;
    logic [1:0]  out_ch;

    always #5 clk = ~clk;

    spi_msg_arbiter #(.N_CH(4), .HOLDOFF(HOLDOFF)) dut (
        .SYS_CLK      (clk),
        .RST          (rst),
        .CH_EN        (ch_en),
        .GOT_FULL_MSG (got),
        .MSG_LEN      (msg_len),
        .FIFO_Q       (fifo_q),
        .RD_REQ       (rd_req),
        .OUT_READY    (out_ready),
        .OUT_DATA     (out_data),
        .OUT_VALID    (out_valid),
        .OUT_SOP      (out_sop),
        .OUT_EOP      (out_eop),
        .OUT_CH       (out_ch),
        .BUSY         (busy)
    );

    // Upstream channel model: FIFO contents plus pending-message lengths.
    fw_t         fifo_mem [4][$];
    logic [7:0]  plen     [4][$];
    logic [15:0] fq       [4];
    logic [3:0]  got_mdl = 4'h0;
    logic [31:0] len_mdl = 32'h0;
    logic        manual  = 1'b0;
    logic [3:0]  got_man = 4'h0;
    logic [31:0] len_man = 32'h0;

    assign got     = manual ? got_man : got_mdl;
    assign msg_len = manual ? len_man : len_mdl;
    assign fifo_q  = {fq[3], fq[2], fq[1], fq[0]};

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                fifo_mem[k].delete();
                plen[k].delete();
                fq[k] <= 16'hA000 + 16'(k);
            end else if (rd_req[k] && fifo_mem[k].size() > 0) begin
                if (fifo_mem[k][0].last && plen[k].size() > 0) void'(plen[k].pop_front());
                fq[k] <= fifo_mem[k][0].d;
                void'(fifo_mem[k].pop_front());
            end
            got_mdl[k]        <= (plen[k].size() > 0);
            len_mdl[8*k +: 8] <= (plen[k].size() > 0) ? plen[k][0] : 8'd0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation logs, sampled mid-cycle.
    int         rd_cyc [$];
    logic [3:0] rd_vec [$];
    logic       rd_rdy [$];
    ow_t        out_log [$];
    int         out_cyc [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_req != 4'h0) begin
                rd_cyc.push_back(cyc);
                rd_vec.push_back(rd_req);
                rd_rdy.push_back(out_ready);
            end
            if (out_valid) begin
                out_log.push_back({out_ch, out_sop, out_eop, out_data});
                out_cyc.push_back(cyc);
            end
        end
    end

    // Reference: whole messages per channel, granted in cyclic order after last_mdl.
    logic [15:0] mw [4][$];
    int          ml [4][$];
    ow_t         exp_q [$];
    int          last_mdl = 3;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_cyc.delete(); rd_vec.delete(); rd_rdy.delete();
        out_log.delete(); out_cyc.delete(); exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_sop"},   32'(out_sop),   32'h0);
        chk({tag, "_eop"},   32'(out_eop),   32'h0);
        chk({tag, "_ch"},    32'(out_ch),    32'h0);
        chk({tag, "_busy"},  32'(busy),      32'h0);
        chk({tag, "_rdreq"}, 32'(rd_req),    32'h0);
        chk({tag, "_data"},  32'(out_data),  32'hA000);
    endtask

    task automatic reset_dut(input bit do_chk, input string tag);
        rst = 1'b1;
        manual = 1'b0;
        got_man = 4'h0;
        len_man = 32'h0;
        out_ready = 1'b1;
        repeat (2) tick();
        if (do_chk) check_reset_outputs(tag);
        for (int k = 0; k < 4; k++) begin
            mw[k].delete();
            ml[k].delete();
        end
        last_mdl = 3;
        clear_logs();
        rst = 1'b0;
    endtask

    task automatic enqueue(input int k, input int len8, input bit to_model);
        int n;
        logic [15:0] d;
        n = (len8 == 0) ? 256 : len8;
        ml[k].push_back(n);
        for (int w = 0; w < n; w++) begin
            d = 16'($urandom);
            mw[k].push_back(d);
            fifo_mem[k].push_back({(w == n - 1), d});
        end
        if (to_model) plen[k].push_back(8'(len8));
    endtask

    task automatic build_expected(input logic [3:0] en);
        bit  found;
        int  c;
        int  n;
        ow_t e;
        do begin
            found = 1'b0;
            for (int i = 1; i <= 4; i++) begin
                c = (last_mdl + i) % 4;
                if (!found && en[c] && ml[c].size() > 0) begin
                    n = ml[c].pop_front();
                    for (int w = 0; w < n; w++) begin
                        e.ch  = 2'(c);
                        e.sop = (w == 0);
                        e.eop = (w == n - 1);
                        e.d   = mw[c].pop_front();
                        exp_q.push_back(e);
                    end
                    last_mdl = c;
                    found = 1'b1;
                end
            end
        end while (found);
    endtask

    // rmode: 0 = ready held high, 1 = ready toggling every cycle, 2 = random ready.
    task automatic run(input string tag, input int max_cyc, input int rmode);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < max_cyc) begin
            tick();
            case (rmode)
                1:       out_ready = (n % 2 == 0);
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
            n++;
            if (n >= 4 && out_log.size() >= exp_q.size() && !busy) done = 1'b1;
        end
        chk({tag, "_timeout"}, 32'(done), 32'h1);
        out_ready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_nwords"}, 32'(out_log.size()), 32'(exp_q.size()));
        chk({tag, "_nreads"}, 32'(rd_cyc.size()),  32'(exp_q.size()));
        for (int i = 0; i < out_log.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_word%0d", tag, i), 32'(out_log[i]), 32'(exp_q[i]));
            if (i < rd_cyc.size()) begin
                chk($sformatf("%s_rdch%0d", tag, i),  32'(rd_vec[i]), 32'(4'b0001 << exp_q[i].ch));
                chk($sformatf("%s_rdrdy%0d", tag, i), 32'(rd_rdy[i]), 32'h1);
                chk($sformatf("%s_lat%0d", tag, i),   32'(out_cyc[i] - rd_cyc[i]), 32'h1);
            end
        end
        $display("%s: %0d words received, %0d expected", tag, out_log.size(), exp_q.size());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int sop_n;
        int ch0_reads;
        int cnt;
        int n;
        int exp_order [5];
        logic [3:0] en;
        int nm;

        exp_order = '{0, 1, 2, 3, 0};

        // Reset state.
        reset_dut(1'b1, "t0_reset");

        // Single channel: 4-word then 2-word message on channel 0.
        enqueue(0, 4, 1'b1);
        enqueue(0, 2, 1'b1);
        t0 = cyc;
        build_expected(4'hF);
        run("t1", 200, 0);
        compare_stream("t1");
        if (rd_cyc.size() >= 6) begin
            chk("t1_grant_latency", 32'(rd_cyc[0] - t0), 32'd2);
            chk("t1_burst_len",     32'(rd_cyc[3] - rd_cyc[0]), 32'd3);
            chk("t1_holdoff",       32'(rd_cyc[4] - rd_cyc[3]), 32'(HOLDOFF + 2));
        end
        chk("t1_ch0_reads", 32'(rd_cyc.size()), 32'd6);

        // Four channels requesting, length 2 each, channel 0 holding a second message.
        reset_dut(1'b0, "t2");
        for (int k = 0; k < 4; k++) enqueue(k, 2, 1'b1);
        enqueue(0, 2, 1'b1);
        build_expected(4'hF);
        run("t2", 300, 0);
        sop_n = 0;
        for (int i = 0; i < out_log.size(); i++) begin
            if (out_log[i].sop) begin
                if (sop_n < 5) chk($sformatf("t2_order%0d", sop_n), 32'(out_log[i].ch), 32'(exp_order[sop_n]));
                sop_n++;
            end
        end
        chk("t2_nmsgs", 32'(sop_n), 32'd5);
        compare_stream("t2");

        // Ready toggling during a 3-word message.
        reset_dut(1'b0, "t3");
        enqueue(1, 3, 1'b1);
        build_expected(4'hF);
        run("t3", 200, 1);
        compare_stream("t3");
        if (rd_cyc.size() >= 3) chk("t3_stall_spacing", 32'(rd_cyc[2] - rd_cyc[0]), 32'd4);

        // MSG_LEN changed from 6 to 2 one cycle after grant.
        reset_dut(1'b0, "t4");
        manual = 1'b1;
        enqueue(0, 6, 1'b0);
        got_man = 4'b0001;
        len_man = 32'd6;
        tick();
        len_man = 32'd2;
        got_man = 4'b0000;
        build_expected(4'hF);
        run("t4", 200, 0);
        compare_stream("t4");
        manual = 1'b0;

        // Channel 0 disabled while all four request.
        reset_dut(1'b0, "t5");
        ch_en = 4'b1110;
        for (int k = 0; k < 4; k++) enqueue(k, $urandom_range(1, 4), 1'b1);
        build_expected(4'b1110);
        run("t5", 300, 0);
        compare_stream("t5");
        ch0_reads = 0;
        for (int i = 0; i < rd_vec.size(); i++) if (rd_vec[i][0]) ch0_reads++;
        chk("t5_ch0_reads", 32'(ch0_reads), 32'd0);
        ch_en = 4'hF;

        // Reset during the third read of a 5-word message on channel 2.
        reset_dut(1'b0, "t6");
        enqueue(2, 5, 1'b1);
        cnt = 0;
        n = 0;
        while (cnt < 3 && n < 50) begin
            @(negedge clk);
            n++;
            if (rd_req[2]) cnt++;
        end
        chk("t6_third_read_seen", 32'(cnt), 32'd3);
        rst = 1'b1;
        #1;
        chk("t6_rdreq_in_reset", 32'(rd_req), 32'h0);
        tick();
        check_reset_outputs("t6_reset");
        for (int k = 0; k < 4; k++) begin
            mw[k].delete();
            ml[k].delete();
        end
        last_mdl = 3;
        clear_logs();
        rst = 1'b0;
        enqueue(3, 2, 1'b1);
        enqueue(1, 3, 1'b1);
        build_expected(4'hF);
        run("t6", 200, 0);
        if (out_log.size() > 0) chk("t6_first_after_reset", 32'(out_log[0].ch), 32'd1);
        compare_stream("t6");

        // Randomized rounds with random enables, lengths and ready pattern.
        for (int r = 0; r < 6; r++) begin
            clear_logs();
            en = 4'($urandom_range(1, 15));
            ch_en = en;
            for (int k = 0; k < 4; k++) begin
                if (en[k]) begin
                    nm = $urandom_range(0, 2);
                    for (int m = 0; m < nm; m++) enqueue(k, $urandom_range(1, 10), 1'b1);
                end
            end
            if (r == 2) begin
                for (int k = 3; k >= 0; k--) begin
                    if (en[k]) t0 = k;
                end
                enqueue(t0, 0, 1'b1);
            end
            build_expected(en);
            run($sformatf("t7_r%0d", r), 3000, 2);
            compare_stream($sformatf("t7_r%0d", r));
        end
        ch_en = 4'hF;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
